// File: rtl/phase_peak_locator.sv
// Streaming float32 argmax over a ROWS x COLS frame, reporting the peak as a wrapped shift or raw index.
// Define PEAK_SECOND_EN to also track the runner-up sample on out_second.
module phase_peak_locator #(
    parameter int unsigned ROWS         = 128,
    parameter int unsigned COLS         = 128,
    parameter int unsigned SIGNED_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_row,
    output logic [31:0] out_col,
    output logic [31:0] out_peak,
    output logic [31:0] out_second,
    output logic        frame_err
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 31;
    localparam logic [0:0] SCAN = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

    logic [0:0]    state, state_d;
    logic [RW-1:0] row_cnt, row_cnt_d, best_r, best_r_d;
    logic [CW-1:0] col_cnt, col_cnt_d, best_c, best_c_d;
    logic [KW-1:0] best_key, best_key_d;
    logic [DW-1:0] best_data, best_data_d;
    logic          in_ready_d, out_valid_d, frame_err_d;
    logic [DW-1:0] out_row_d, out_col_d, out_peak_d;

    logic          accept, at_origin, term, frame_end, upd, is_nan;
    logic [KW-1:0] key;
    logic [RW-1:0] win_r;
    logic [CW-1:0] win_c;

    // Negative values and NaNs compete as zero; non-negative float order equals unsigned bit order
    assign is_nan    = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    assign key       = (in_data[31] || is_nan) ? '0 : in_data[30:0];
    assign accept    = in_valid && in_ready;
    assign at_origin = (row_cnt == '0) && (col_cnt == '0);
    assign term      = (row_cnt == RW'(ROWS - 1)) && (col_cnt == CW'(COLS - 1));
    assign frame_end = accept && (in_last || term);
    assign upd       = accept && (at_origin || (key > best_key));
    assign win_r     = upd ? row_cnt : best_r;
    assign win_c     = upd ? col_cnt : best_c;

    function automatic logic [DW-1:0] map_row(input logic [RW-1:0] r);
        if (SIGNED_SHIFT != 0) return {{(DW - RW){r[RW-1]}}, r};
        return DW'(r);
    endfunction

    function automatic logic [DW-1:0] map_col(input logic [CW-1:0] c);
        if (SIGNED_SHIFT != 0) return {{(DW - CW){c[CW-1]}}, c};
        return DW'(c);
    endfunction

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        row_cnt_d   = row_cnt;
        col_cnt_d   = col_cnt;
        best_key_d  = best_key;
        best_data_d = best_data;
        best_r_d    = best_r;
        best_c_d    = best_c;
        out_row_d   = out_row;
        out_col_d   = out_col;
        out_peak_d  = out_peak;
        frame_err_d = frame_err;
        if (upd) begin
            best_key_d  = key;
            best_data_d = in_data;
            best_r_d    = row_cnt;
            best_c_d    = col_cnt;
        end
        case (state)
            SCAN: begin
                if (frame_end) begin
                    row_cnt_d   = '0;
                    col_cnt_d   = '0;
                    state_d     = DONE;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_row_d   = map_row(win_r);
                    out_col_d   = map_col(win_c);
                    out_peak_d  = upd ? in_data : best_data;
                    frame_err_d = in_last != term;
                end else if (accept) begin
                    if (col_cnt == CW'(COLS - 1)) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt + RW'(1);
                    end else begin
                        col_cnt_d = col_cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = SCAN;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            best_key  <= '0;
            best_data <= '0;
            best_r    <= '0;
            best_c    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_peak  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            row_cnt   <= row_cnt_d;
            col_cnt   <= col_cnt_d;
            best_key  <= best_key_d;
            best_data <= best_data_d;
            best_r    <= best_r_d;
            best_c    <= best_c_d;
            out_row   <= out_row_d;
            out_col   <= out_col_d;
            out_peak  <= out_peak_d;
            frame_err <= frame_err_d;
        end
    end

`ifdef PEAK_SECOND_EN
    logic [KW-1:0] sec_key, sec_key_d;
    logic [DW-1:0] sec_data, sec_data_d, out_second_d, out_second_q;

    // A displaced best becomes the runner-up; the first sample of a frame clears it
    always_comb begin
        sec_key_d  = sec_key;
        sec_data_d = sec_data;
        if (upd) begin
            sec_key_d  = at_origin ? '0 : best_key;
            sec_data_d = at_origin ? '0 : best_data;
        end else if (accept && (key > sec_key)) begin
            sec_key_d  = key;
            sec_data_d = in_data;
        end
        out_second_d = frame_end ? sec_data_d : out_second_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_key      <= '0;
            sec_data     <= '0;
            out_second_q <= '0;
        end else begin
            sec_key      <= sec_key_d;
            sec_data     <= sec_data_d;
            out_second_q <= out_second_d;
        end
    end

    assign out_second = out_second_q;
`else
    assign out_second = '0;
`endif

endmodule

// File: tb/tb_phase_peak_locator.sv
// Bench for phase_peak_locator: a 4x8 raw-index instance and a 128x128 signed-shift instance,
// driven with directed and random frames and checked against a real-valued argmax model.
module tb_phase_peak_locator;
    localparam int unsigned AR = 4;
    localparam int unsigned AC = 8;
    localparam int unsigned BR = 128;
    localparam int unsigned BC = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'd0;

    logic        a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_frame_err;
    logic        b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_frame_err;
    logic [31:0] a_row, a_col, a_peak, a_second, b_row, b_col, b_peak, b_second;
    logic        o_in_ready, o_valid, o_err;
    logic [31:0] o_row, o_col, o_peak, o_second;

    int total = 0;
    int bad = 0;
    logic [31:0] frm[$];
    logic [31:0] exp_row, exp_col, exp_peak, exp_err, exp_sec;
    logic [31:0] obs_row, obs_col, obs_peak, obs_err, obs_sec;

    always #5 clk = ~clk;

    assign a_in_valid  = in_valid & ~sel;
    assign b_in_valid  = in_valid & sel;
    assign a_out_ready = out_ready & ~sel;
    assign b_out_ready = out_ready & sel;
    assign o_in_ready  = sel ? b_in_ready : a_in_ready;
    assign o_valid     = sel ? b_out_valid : a_out_valid;
    assign o_err       = sel ? b_frame_err : a_frame_err;
    assign o_row       = sel ? b_row : a_row;
    assign o_col       = sel ? b_col : a_col;
    assign o_peak      = sel ? b_peak : a_peak;
    assign o_second    = sel ? b_second : a_second;

    phase_peak_locator #(.ROWS(AR), .COLS(AC), .SIGNED_SHIFT(0)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_row(a_row), .out_col(a_col), .out_peak(a_peak), .out_second(a_second),
        .frame_err(a_frame_err)
    );

    phase_peak_locator #(.ROWS(BR), .COLS(BC), .SIGNED_SHIFT(1)) u_big (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_row(b_row), .out_col(b_col), .out_peak(b_peak), .out_second(b_second),
        .frame_err(b_frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Float32 bits to real; negatives and NaN count as zero, +Inf above every finite value
    function automatic real mag(input logic [31:0] b);
        int e;
        int m;
        e = int'(b[30:23]);
        m = int'(b[22:0]);
        if (b[31]) return 0.0;
        if (e == 255) return (m != 0) ? 0.0 : 1.0e300;
        if (e == 0) return real'(m) * 2.0 ** (-149.0);
        return real'(m + 8388608) * 2.0 ** (real'(e) - 150.0);
    endfunction

    function automatic logic [31:0] rnd_sample();
        logic [31:0] v;
        case ($urandom_range(0, 15))
            0: v = 32'h8000_0000 | $urandom();
            1: v = {9'h0FF, 23'($urandom_range(1, 8388607))};
            2: v = 32'h0000_0000;
            3: v = 32'h8000_0000;
            4: v = ($urandom_range(0, 7) == 0) ? 32'h7F80_0000 : 32'h3F80_0000;
            default: v = {1'b0, 8'(124 + $urandom_range(0, 4)), 23'($urandom_range(0, 3) << 21)};
        endcase
        return v;
    endfunction

    task automatic model(input logic s, input bit with_last);
        int rows, cols, n, w, r, c, si;
        real bv, sv;
        rows = s ? int'(BR) : int'(AR);
        cols = s ? int'(BC) : int'(AC);
        n = frm.size();
        w = 0;
        bv = mag(frm[0]);
        for (int i = 1; i < n; i++) begin
            if (mag(frm[i]) > bv) begin
                bv = mag(frm[i]);
                w = i;
            end
        end
        r = w / cols;
        c = w % cols;
        if (s) begin
            if (r >= rows / 2) r = r - rows;
            if (c >= cols / 2) c = c - cols;
        end
        exp_row  = 32'(r);
        exp_col  = 32'(c);
        exp_peak = frm[w];
        exp_err  = ((n != rows * cols) || !with_last) ? 32'd1 : 32'd0;
        sv = -1.0;
        si = -1;
        for (int i = 0; i < n; i++) begin
            if (i != w && mag(frm[i]) > sv) begin
                sv = mag(frm[i]);
                si = i;
            end
        end
        if (si < 0)        exp_sec = 32'd0;
        else if (sv > 0.0) exp_sec = frm[si];
        else if (w != 0)   exp_sec = frm[0];
        else               exp_sec = 32'd0;
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        int guard;
        guard = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!o_in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!o_in_ready) check("accept_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input logic s, input bit with_last, input int hold);
        int n;
        n = frm.size();
        sel = s;
        model(s, with_last);
        for (int i = 0; i < n; i++) begin
            if (!s) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (i == n - 1) check("valid_early", 32'(o_valid), 32'd0);
            push(frm[i], with_last && (i == n - 1));
        end
        obs_row = o_row; obs_col = o_col; obs_peak = o_peak; obs_err = 32'(o_err); obs_sec = o_second;
        check("out_valid", 32'(o_valid), 32'd1);
        check("out_row", o_row, exp_row);
        check("out_col", o_col, exp_col);
        check("out_peak", o_peak, exp_peak);
        check("frame_err", 32'(o_err), exp_err);
`ifdef PEAK_SECOND_EN
        check("out_second", o_second, exp_sec);
`else
        check("out_second", o_second, 32'd0);
`endif
        check("in_ready_done", 32'(o_in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_in_ready", 32'(o_in_ready), 32'd0);
            check("hold_row", o_row, exp_row);
            check("hold_peak", o_peak, exp_peak);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(o_valid), 32'd0);
        check("release_in_ready", 32'(o_in_ready), 32'd1);
    endtask

    task automatic fill(input int n, input logic [31:0] v);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(v);
    endtask

    task automatic fill_rnd(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(rnd_sample());
    endtask

    task automatic check_reset_state();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_in_ready", 32'(o_in_ready), 32'd1);
        check("rst_row", o_row, 32'd0);
        check("rst_col", o_col, 32'd0);
        check("rst_peak", o_peak, 32'd0);
        check("rst_second", o_second, 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 128x128 signed shift: single 5.0 at (3,120)
        fill(BR * BC, 32'h3F80_0000);
        frm[3 * BC + 120] = 32'h40A0_0000;
        run_frame(1'b1, 1'b1, 0);
        check("big_row", obs_row, 32'd3);
        check("big_col", obs_col, 32'hFFFF_FFF8);
        check("big_peak", obs_peak, 32'h40A0_0000);
        check("big_err", obs_err, 32'd0);

        // Equal peaks: first occurrence wins
        fill(AR * AC, 32'h3F80_0000);
        frm[1 * AC + 2] = 32'h4000_0000;
        frm[3 * AC + 7] = 32'h4000_0000;
        run_frame(1'b0, 1'b1, 0);
        check("tie_row", obs_row, 32'd1);
        check("tie_col", obs_col, 32'd2);

        // Raw index at the last position
        fill(AR * AC, 32'h3F80_0000);
        frm[3 * AC + 7] = 32'h4000_0000;
        run_frame(1'b0, 1'b1, 0);
        check("raw_row", obs_row, 32'd3);
        check("raw_col", obs_col, 32'd7);

        // Negative and NaN samples never win
        fill(AR * AC, 32'h3E80_0000);
        frm[0] = 32'hC110_0000;
        frm[1] = 32'h3F00_0000;
        frm[5] = 32'h7FC0_0000;
        run_frame(1'b0, 1'b1, 0);
        check("val_col", obs_col, 32'd1);
        check("val_peak", obs_peak, 32'h3F00_0000);

        // Early in_last, then a frame proving the counters restarted at (0,0)
        fill_rnd(11);
        run_frame(1'b0, 1'b1, 0);
        check("early_err", obs_err, 32'd1);
        fill(AR * AC, 32'h3F80_0000);
        frm[9] = 32'h4100_0000;
        run_frame(1'b0, 1'b1, 0);
        check("restart_row", obs_row, 32'd1);
        check("restart_col", obs_col, 32'd1);

        // Full count with no in_last
        fill_rnd(AR * AC);
        run_frame(1'b0, 1'b0, 0);
        check("nolast_err", obs_err, 32'd1);

        // Backpressure for 20 cycles
        fill_rnd(AR * AC);
        run_frame(1'b0, 1'b1, 20);

        // Runner-up tracking
        frm.delete();
        frm.push_back(32'h4040_0000);
        frm.push_back(32'h40E0_0000);
        frm.push_back(32'h40A0_0000);
        run_frame(1'b0, 1'b1, 0);
        check("sec_peak", obs_peak, 32'h40E0_0000);
`ifdef PEAK_SECOND_EN
        check("sec_second", obs_sec, 32'h40A0_0000);
`else
        check("sec_second", obs_sec, 32'd0);
`endif

        // Random frames of random length and termination
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 2))
                0: begin n = int'($urandom_range(1, AR * AC - 1)); fill_rnd(n); run_frame(1'b0, 1'b1, int'($urandom_range(0, 3))); end
                1: begin fill_rnd(AR * AC); run_frame(1'b0, 1'b1, int'($urandom_range(0, 3))); end
                default: begin fill_rnd(AR * AC); run_frame(1'b0, 1'b0, int'($urandom_range(0, 3))); end
            endcase
        end

        // Reset in the middle of a frame discards it
        sel = 1'b0;
        for (int i = 0; i < 10; i++) push(rnd_sample(), 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check("post_rst_valid", 32'(o_valid), 32'd0);
            @(posedge clk); #1;
        end
        fill_rnd(AR * AC);
        run_frame(1'b0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
